// File: rtl/maxpool_relu1.sv
// 2x2 stride-2 max pooling followed by ReLU over three lockstep channels.
// Input is a signed raster stream; the output is one non-negative value per pooled pixel.
module maxpool_relu1 #(
    parameter int unsigned CONV_BIT    = 12,
    parameter int unsigned HALF_WIDTH  = 12,
    parameter int unsigned HALF_HEIGHT = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic signed [CONV_BIT-1:0] conv_out_1,
    input  logic signed [CONV_BIT-1:0] conv_out_2,
    input  logic signed [CONV_BIT-1:0] conv_out_3,
    output logic        [CONV_BIT-1:0] max_value_1,
    output logic        [CONV_BIT-1:0] max_value_2,
    output logic        [CONV_BIT-1:0] max_value_3,
    output logic                       valid_out_relu,
    output logic                       frame_done
);

    localparam int unsigned NCH  = 3;
    localparam int unsigned COLS = 2 * HALF_WIDTH;
    localparam int unsigned ROWS = 2 * HALF_HEIGHT;
    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned BW   = CW - 1;

    typedef logic signed [CONV_BIT-1:0] pix_t;

    pix_t                conv_in  [NCH];
    pix_t                h_q      [NCH];
    pix_t                h_d      [NCH];
    pix_t                line_q   [NCH][HALF_WIDTH];
    pix_t                pm       [NCH];
    pix_t                pair_max [NCH];
    logic [CONV_BIT-1:0] max_q    [NCH];
    logic [CONV_BIT-1:0] max_d    [NCH];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          vout_q, vout_d;
    logic          fd_q, fd_d;
    logic [BW-1:0] bidx;
    logic          col_last, row_last, odd_col, odd_row;
    logic          emit, store;

    assign conv_in[0] = conv_out_1;
    assign conv_in[1] = conv_out_2;
    assign conv_in[2] = conv_out_3;

    assign bidx     = col_q[CW-1:1];
    assign odd_col  = col_q[0];
    assign odd_row  = row_q[0];
    assign col_last = (col_q == CW'(COLS - 1));
    assign row_last = (row_q == RW'(ROWS - 1));
    assign emit     = valid_in & odd_row & odd_col;
    assign store    = valid_in & ~odd_row & odd_col;

    // Horizontal pair max, then vertical max against the buffered even-row result.
    always_comb begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            pm[ch]       = (h_q[ch] > conv_in[ch]) ? h_q[ch] : conv_in[ch];
            pair_max[ch] = (line_q[ch][bidx] > pm[ch]) ? line_q[ch][bidx] : pm[ch];
        end
    end

    // Next-state: position counters, hold register, registered outputs.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        h_d    = h_q;
        max_d  = max_q;
        vout_d = 1'b0;
        fd_d   = 1'b0;
        if (valid_in) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
            end
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (!odd_col) begin
                    h_d[ch] = conv_in[ch];
                end
            end
        end
        if (emit) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                max_d[ch] = pair_max[ch][CONV_BIT-1] ? '0 : unsigned'(pair_max[ch]);
            end
            vout_d = 1'b1;
            fd_d   = row_last & col_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            vout_q <= 1'b0;
            fd_q   <= 1'b0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                h_q[ch]   <= '0;
                max_q[ch] <= '0;
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            vout_q <= vout_d;
            fd_q   <= fd_d;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                h_q[ch]   <= h_d[ch];
                max_q[ch] <= max_d[ch];
            end
        end
    end

    // Row buffer is never reset: each entry is rewritten in the even row before use.
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                line_q[ch][bidx] <= pm[ch];
            end
        end
    end

    assign max_value_1    = max_q[0];
    assign max_value_2    = max_q[1];
    assign max_value_3    = max_q[2];
    assign valid_out_relu = vout_q;
    assign frame_done     = fd_q;

endmodule

// File: tb/tb_maxpool_relu1.sv
// Directed bench for maxpool_relu1: closed-form expected pooled values per frame pattern.
module tb_maxpool_relu1;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic signed [11:0] c1, c2, c3;
    logic        [11:0] m1, m2, m3;
    logic               vout, fd;

    int   total = 0;
    int   bad   = 0;
    int   row   = 0;
    int   col   = 0;
    logic exp_v  = 1'b0;
    logic exp_fd = 1'b0;
    int   e1 = 0, e2 = 0, e3 = 0;
    int   n_pulse = 0;
    int   n_fd    = 0;

    always #5 clk = ~clk;

    maxpool_relu1 dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .conv_out_1    (c1),
        .conv_out_2    (c2),
        .conv_out_3    (c3),
        .max_value_1   (m1),
        .max_value_2   (m2),
        .max_value_3   (m3),
        .valid_out_relu(vout),
        .frame_done    (fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    // Input patterns: test 0 = ramp frame, test 1 = reversed ramp frame.
    function automatic int gen(input int t, input int ch, input int r, input int c);
        if (t == 0) begin
            if (ch == 1) return r * 24 + c;
            if (ch == 2) return -5;
            return (r == 2 && c == 3) ? 2047 : -100;
        end
        if (ch == 1) return 575 - (r * 24 + c);
        if (ch == 2) return (r == 5 && c == 7) ? -2048 : 0;
        return c - 12;
    endfunction

    // Hand-derived pooled results for pooled pixel (pr, pc).
    function automatic int expo(input int t, input int ch, input int pr, input int pc);
        if (t == 0) begin
            if (ch == 1) return (2 * pr + 1) * 24 + 2 * pc + 1;
            if (ch == 2) return 0;
            return (pr == 1 && pc == 1) ? 2047 : 0;
        end
        if (ch == 1) return 575 - ((2 * pr) * 24 + 2 * pc);
        if (ch == 2) return 0;
        return (2 * pc - 11 > 0) ? 2 * pc - 11 : 0;
    endfunction

    task automatic check_outputs();
        chk("valid_out_relu", 32'(vout), 32'(exp_v));
        chk("frame_done", 32'(fd), 32'(exp_fd));
        chk("max_value_1", 32'(m1), 32'(12'(e1)));
        chk("max_value_2", 32'(m2), 32'(12'(e2)));
        chk("max_value_3", 32'(m3), 32'(12'(e3)));
        if (vout === 1'b1) n_pulse++;
        if (fd === 1'b1) n_fd++;
    endtask

    task automatic pixel(input int t);
        @(negedge clk);
        check_outputs();
        rst      = 1'b0;
        valid_in = 1'b1;
        c1 = 12'(gen(t, 1, row, col));
        c2 = 12'(gen(t, 2, row, col));
        c3 = 12'(gen(t, 3, row, col));
        if ((row % 2) == 1 && (col % 2) == 1) begin
            exp_v  = 1'b1;
            exp_fd = (row == 23 && col == 23);
            e1 = expo(t, 1, row / 2, col / 2);
            e2 = expo(t, 2, row / 2, col / 2);
            e3 = expo(t, 3, row / 2, col / 2);
        end else begin
            exp_v  = 1'b0;
            exp_fd = 1'b0;
        end
        if (col == 23) begin
            col = 0;
            row = (row == 23) ? 0 : row + 1;
        end else begin
            col = col + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        check_outputs();
        rst      = 1'b0;
        valid_in = 1'b0;
        c1 = 12'($urandom);
        c2 = 12'($urandom);
        c3 = 12'($urandom);
        exp_v  = 1'b0;
        exp_fd = 1'b0;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            rst      = 1'b1;
            valid_in = 1'b1;
            c1 = 12'($urandom);
            c2 = 12'($urandom);
            c3 = 12'($urandom);
            exp_v  = 1'b0;
            exp_fd = 1'b0;
            e1 = 0;
            e2 = 0;
            e3 = 0;
            row = 0;
            col = 0;
        end
    endtask

    task automatic frame(input int t, input bit gapped);
        for (int i = 0; i < 576; i++) begin
            pixel(t);
            if (gapped) idle();
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b1;
        c1 = 12'($urandom);
        c2 = 12'($urandom);
        c3 = 12'($urandom);

        // Reset held with valid high: outputs must be zero.
        do_reset(2);

        // Reset coincident with an output-producing pixel suppresses the pulse.
        for (int i = 0; i < 25; i++) pixel(0);
        do_reset(1);

        // Contiguous ramp frame.
        n_pulse = 0;
        n_fd    = 0;
        frame(0, 1'b0);
        idle();
        chk("ramp_pulses", 32'(n_pulse), 32'd144);
        chk("ramp_frame_done", 32'(n_fd), 32'd1);

        // Same frame with valid_in alternating.
        n_pulse = 0;
        n_fd    = 0;
        frame(0, 1'b1);
        idle();
        chk("gap_pulses", 32'(n_pulse), 32'd144);
        chk("gap_frame_done", 32'(n_fd), 32'd1);

        // Abandon a partial frame, then a full frame.
        for (int i = 0; i < 300; i++) pixel(0);
        n_pulse = 0;
        n_fd    = 0;
        do_reset(1);
        frame(0, 1'b0);
        idle();
        chk("midrst_pulses", 32'(n_pulse), 32'd144);
        chk("midrst_frame_done", 32'(n_fd), 32'd1);

        // Back-to-back frames with no idle cycle.
        n_pulse = 0;
        n_fd    = 0;
        frame(0, 1'b0);
        frame(1, 1'b0);
        idle();
        idle();
        chk("b2b_pulses", 32'(n_pulse), 32'd288);
        chk("b2b_frame_done", 32'(n_fd), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
